// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus width, funct3
// access codes and a legality helper for the size/sign field.
package dmem_responder_pkg;

    localparam int DATA_W = 32;

    // funct3 access size / sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // True when funct3 names a real access of the given direction.
    // Stores only have the signed encodings (SB/SH/SW).
    function automatic logic f3_is_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (!is_store && ((f3 == F3_LBU) || (f3 == F3_LHU)));
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data RAM: builds byte enables
// and replicated write data for stores, extracts and extends load data,
// and flags misaligned or illegal funct3 accesses.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]        i_f3,
    input  logic [1:0]        i_addr_lo,
    input  logic              i_is_store,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rword,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_misaligned,
    output logic              o_illegal_f3
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    // Lane selection, write replication and load extension by access size
    always_comb begin
        byte_sel     = i_rword[{i_addr_lo, 3'b000} +: 8];
        half_sel     = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        sign_ext     = ~i_f3[2];
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_rdata      = '0;
        o_misaligned = 1'b0;
        o_illegal_f3 = ~f3_is_legal(i_f3, i_is_store);
        case (i_f3)
            F3_LB, F3_LBU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{byte_sel[7] & sign_ext}}, byte_sel};
            end
            F3_LH, F3_LHU: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{half_sel[15] & sign_ext}}, half_sel};
                o_misaligned = i_addr_lo[0];
            end
            F3_LW: begin
                o_be         = 4'b1111;
                o_rdata      = i_rword;
                o_misaligned = |i_addr_lo;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the hart data-memory interface. Accepts one load or
// store at a time from IDLE, holds it for WAIT_STATES cycles, then
// completes with a one-cycle o_DM_data_ready pulse. The request is
// latched on acceptance; request inputs are ignored outside IDLE.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_DM_MemRead,
    input  logic              i_DM_Wen,
    input  logic [31:0]       i_DM_Addr,
    input  logic [DATA_W-1:0] i_DM_WriteData,
    input  logic [2:0]        i_DM_f3,
    output logic              o_DM_data_ready,
    output logic [DATA_W-1:0] o_DM_ReadData,
    output logic              o_DM_fault
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN      = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rword_q;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Access currently being worked on: live inputs in IDLE, latched copy otherwise
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [2:0]        acc_f3;
    logic              acc_rd, acc_wr;
    logic              req_in;
    logic [31:0]       offset;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              acc_fault;
    logic              enter_resp;

    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              lane_misaligned;
    logic              lane_illegal;

    // Select the access view and evaluate its fault conditions
    always_comb begin
        req_in    = i_DM_MemRead | i_DM_Wen;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_f3    = f3_q;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
        if (state_q == ST_IDLE) begin
            acc_addr  = i_DM_Addr;
            acc_wdata = i_DM_WriteData;
            acc_f3    = i_DM_f3;
            acc_rd    = i_DM_MemRead;
            acc_wr    = i_DM_Wen;
        end
        offset     = acc_addr - ADDR_BASE;
        in_range   = offset < SPAN;
        idx        = offset[IDX_W+1:2];
        acc_fault  = (acc_rd & acc_wr) | lane_illegal | lane_misaligned | ~in_range;
        enter_resp = ((state_q == ST_IDLE) && req_in && (WAIT_STATES == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    end

    dmem_lane_align u_lane_align (
        .i_f3         (acc_f3),
        .i_addr_lo    (acc_addr[1:0]),
        .i_is_store   (acc_wr),
        .i_wdata      (acc_wdata),
        .i_rword      (rword_q),
        .o_be         (lane_be),
        .o_wdata      (lane_wdata),
        .o_rdata      (lane_rdata),
        .o_misaligned (lane_misaligned),
        .o_illegal_f3 (lane_illegal)
    );

    // Next-state, request latch and completion flags
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ready_d = enter_resp;
        fault_d = enter_resp & acc_fault;
        case (state_q)
            ST_IDLE: begin
                if (req_in) begin
                    addr_d  = i_DM_Addr;
                    wdata_d = i_DM_WriteData;
                    f3_d    = i_DM_f3;
                    rd_d    = i_DM_MemRead;
                    wr_d    = i_DM_Wen;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and control registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    // RAM: read word and byte-enabled write both happen on the edge entering RESP;
    // a reset on that edge cancels the write, and RAM is never cleared
    always_ff @(posedge i_clk) begin
        if (enter_resp) begin
            rword_q <= mem[idx];
            if (!i_rst && acc_wr && !acc_fault) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_be[b]) begin
                        mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign o_DM_data_ready = ready_q;
    assign o_DM_fault      = fault_q;
    assign o_DM_ReadData   = (ready_q && !fault_q) ? lane_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_STATES 2, 0 and 3, the
// last with a non-zero base) checked against a byte-array memory model.
module tb_dmem_responder;

    localparam int NW = 64;

    logic        clk = 1'b0;
    logic        rst    [3];
    logic        rd     [3];
    logic        wr     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [2:0]  f3     [3];
    logic        rdy    [3];
    logic [31:0] rdata  [3];
    logic        flt    [3];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ref_mem [3][4*NW];

    always #5 clk = ~clk;

    dmem_responder #(.MEM_WORDS(NW), .WAIT_STATES(2), .ADDR_BASE(32'h0000_0000)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_DM_MemRead(rd[0]), .i_DM_Wen(wr[0]),
        .i_DM_Addr(addr[0]), .i_DM_WriteData(wdata[0]), .i_DM_f3(f3[0]),
        .o_DM_data_ready(rdy[0]), .o_DM_ReadData(rdata[0]), .o_DM_fault(flt[0])
    );

    dmem_responder #(.MEM_WORDS(NW), .WAIT_STATES(0), .ADDR_BASE(32'h0000_0000)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_DM_MemRead(rd[1]), .i_DM_Wen(wr[1]),
        .i_DM_Addr(addr[1]), .i_DM_WriteData(wdata[1]), .i_DM_f3(f3[1]),
        .o_DM_data_ready(rdy[1]), .o_DM_ReadData(rdata[1]), .o_DM_fault(flt[1])
    );

    dmem_responder #(.MEM_WORDS(NW), .WAIT_STATES(3), .ADDR_BASE(32'h0000_0100)) u_dut2 (
        .i_clk(clk), .i_rst(rst[2]), .i_DM_MemRead(rd[2]), .i_DM_Wen(wr[2]),
        .i_DM_Addr(addr[2]), .i_DM_WriteData(wdata[2]), .i_DM_f3(f3[2]),
        .o_DM_data_ready(rdy[2]), .o_DM_ReadData(rdata[2]), .o_DM_fault(flt[2])
    );

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 0 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction

    function automatic logic [31:0] size_of(input logic [2:0] f);
        return 32'd1 << f[1:0];
    endfunction

    // Reference fault rules, stated directly in terms of size, alignment and range
    function automatic logic model_fault(input int k, input logic r, input logic w,
                                         input logic [31:0] a, input logic [2:0] f);
        logic [31:0] sz;
        logic [31:0] off;
        if (r && w) return 1'b1;
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
        if (w && f >= 3'd4) return 1'b1;
        sz = size_of(f);
        if ((a % sz) != 0) return 1'b1;
        off = a - base_of(k);
        if (off >= 32'(4 * NW)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [31:0] a, input logic [2:0] f);
        logic [31:0] sz;
        logic [31:0] off;
        logic [31:0] v;
        sz  = size_of(f);
        off = a - base_of(k);
        v   = 32'd0;
        for (int i = 0; i < int'(sz); i++) begin
            v = v | (32'(ref_mem[k][int'(off) + i]) << (8 * i));
        end
        if (f < 3'd4 && sz < 32'd4 && v[8*sz-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * sz));
        end
        return v;
    endfunction

    task automatic model_store(input int k, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        logic [31:0] sz;
        logic [31:0] off;
        sz  = size_of(f);
        off = a - base_of(k);
        for (int i = 0; i < int'(sz); i++) begin
            ref_mem[k][int'(off) + i] = d[8*i +: 8];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance k, checked for latency, fault, data and pulse width
    task automatic do_access(input int k, input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] f, output logic [31:0] obs);
        logic        ef;
        logic [31:0] ed;
        int          cyc;
        string       tag;
        tag = $sformatf("k%0d r%0d w%0d a=%h f3=%0d", k, r, w, a, f);
        ef  = model_fault(k, r, w, a, f);
        ed  = 32'd0;
        if (!ef && r) ed = model_load(k, a, f);
        if (!ef && w) model_store(k, a, d, f);
        @(negedge clk);
        rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; f3[k] = f;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rdy[k] && cyc < 30);
        check({tag, " latency"}, cyc, ws_of(k) + 1);
        check({tag, " fault"}, {31'd0, flt[k]}, {31'd0, ef});
        if (r || ef) check({tag, " rdata"}, rdata[k], ed);
        obs = rdata[k];
        rd[k] = 1'b0; wr[k] = 1'b0;
        @(negedge clk);
        check({tag, " pulse_width"}, {31'd0, rdy[k]}, 32'd0);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] exp_a, exp_b, old_v, a;
        logic [2:0]  f;
        int          sel;
        logic        r, w;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0;
            addr[k] = '0; wdata[k] = '0; f3[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // Reset state
        for (int k = 0; k < 3; k++) begin
            check($sformatf("k%0d reset ready", k), {31'd0, rdy[k]}, 32'd0);
            check($sformatf("k%0d reset fault", k), {31'd0, flt[k]}, 32'd0);
            check($sformatf("k%0d reset rdata", k), rdata[k], 32'd0);
        end

        // Fill every word so later loads have known contents
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NW; i++) begin
                do_access(k, 1'b0, 1'b1, base_of(k) + 32'(4 * i), $urandom, 3'b010, obs);
            end
        end

        // Directed sub-word and fault cases on the two-wait-state instance
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, obs);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, obs);
        check("lw_after_sw", obs, 32'hDEAD_BEEF);
        do_access(0, 1'b0, 1'b1, 32'h11, 32'h0000_00A5, 3'b000, obs);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, obs);
        check("lw_after_sb", obs, 32'hDEAD_A5EF);
        do_access(0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b000, obs);
        check("lb_signed", obs, 32'hFFFF_FFA5);
        do_access(0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b100, obs);
        check("lbu", obs, 32'h0000_00A5);
        do_access(0, 1'b0, 1'b1, 32'h22, 32'h0000_8001, 3'b001, obs);
        do_access(0, 1'b1, 1'b0, 32'h22, 32'h0, 3'b001, obs);
        check("lh_signed", obs, 32'hFFFF_8001);
        do_access(0, 1'b1, 1'b0, 32'h22, 32'h0, 3'b101, obs);
        check("lhu", obs, 32'h0000_8001);
        do_access(0, 1'b1, 1'b0, 32'h23, 32'h0, 3'b001, obs);
        do_access(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, obs);
        do_access(0, 1'b1, 1'b0, 32'(4 * NW), 32'h0, 3'b010, obs);
        do_access(0, 1'b1, 1'b0, 32'h14, 32'h0, 3'b011, obs);
        do_access(0, 1'b0, 1'b1, 32'h10, 32'h0000_0077, 3'b100, obs);
        do_access(0, 1'b1, 1'b1, 32'h10, 32'h0000_0055, 3'b010, obs);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, obs);
        check("no_write_on_fault", obs, 32'hDEAD_A5EF);

        // Zero-wait instance with the load held across two addresses
        exp_a = model_load(1, 32'h18, 3'b010);
        exp_b = model_load(1, 32'h2C, 3'b010);
        @(negedge clk);
        rd[1] = 1'b1; f3[1] = 3'b010; addr[1] = 32'h18;
        @(posedge clk);
        @(negedge clk);
        check("b2b first ready", {31'd0, rdy[1]}, 32'd1);
        check("b2b first data", rdata[1], exp_a);
        addr[1] = 32'h2C;
        @(negedge clk);
        check("b2b idle gap", {31'd0, rdy[1]}, 32'd0);
        @(negedge clk);
        check("b2b second ready", {31'd0, rdy[1]}, 32'd1);
        check("b2b second data", rdata[1], exp_b);
        rd[1] = 1'b0;
        @(negedge clk);
        check("b2b after", {31'd0, rdy[1]}, 32'd0);

        // Reset during WAIT discards the pending store
        a     = 32'h0000_0130;
        old_v = model_load(2, a, 3'b010);
        @(negedge clk);
        wr[2] = 1'b1; addr[2] = a; wdata[2] = 32'h1234_5678; f3[2] = 3'b010;
        @(posedge clk);
        @(negedge clk);
        check("rst_wait ready", {31'd0, rdy[2]}, 32'd0);
        rst[2] = 1'b1; wr[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("rst_no_pulse", {31'd0, rdy[2]}, 32'd0);
            @(negedge clk);
        end
        do_access(2, 1'b1, 1'b0, a, 32'h0, 3'b010, obs);
        check("rst_store_discarded", obs, old_v);

        // Randomized mix of loads, stores, faults and out-of-range addresses
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 80; i++) begin
                sel = $urandom_range(0, 9);
                r   = (sel == 0) || (sel > 4);
                w   = (sel <= 4);
                f   = 3'($urandom_range(0, 7));
                a   = base_of(k) + 32'($urandom_range(0, 4 * NW + 15)) - 32'd8;
                if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
                do_access(k, r, w, a, $urandom, f, obs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
